// File: rtl/frame_pkg.sv
// Shared types and default geometry for the frame writer.
package frame_pkg;

  localparam int unsigned DEF_IMG_W = 64;
  localparam int unsigned DEF_IMG_H = 64;
  localparam int unsigned DEF_PIX_W = 8;

  localparam int unsigned INT_W      = DEF_IMG_W - 2;
  localparam int unsigned INT_H      = DEF_IMG_H - 2;
  localparam int unsigned BORDER_CNT = 2 * DEF_IMG_W + 2 * (DEF_IMG_H - 2);

  typedef enum logic [1:0] {IDLE, RUN, FILL, DONE} fw_state_t;

endpackage

// File: rtl/border_scanner.sv
// Walks the frame border in fill order: top row, then left/right pairs, then bottom row.
module border_scanner #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              edge_row;

  assign edge_row = (row_q == '0) || (row_q == ROW_END);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q + ADDR_W'(1);
    if (edge_row) begin
      if (col_q == COL_END) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (col_q == '0) begin
      // Jump straight across the interior to the right-hand border pixel.
      col_d  = COL_END;
      addr_d = addr_q + ADDR_W'(IMG_W - 1);
    end else begin
      col_d = '0;
      row_d = row_q + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (step) begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (row_q == ROW_END) && (col_q == COL_END);

endmodule

// File: rtl/frame_writer.sv
// Writes the raster stream of interior filter results into an IMG_W x IMG_H frame memory.
// Optional border zero-fill is enabled with FRAME_WRITER_BORDER_FILL_EN.
module frame_writer
  import frame_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned PIX_W  = DEF_PIX_W,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_enb,
  input  logic [PIX_W-1:0]  i_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [PIX_W-1:0]  o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 3);
  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  fw_state_t         state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  // Address of interior pixel (row+1, 1); advanced by IMG_W per row instead of multiplying.
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              overrun_q, overrun_d;
  logic              done_q, done_d;

`ifdef FRAME_WRITER_BORDER_FILL_EN
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_last;

  border_scanner #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_border_scanner (
    .clk   (i_clk),
    .rst   (i_rst),
    .start ((state_q == IDLE) && i_start),
    .step  (state_q == FILL),
    .addr  (scan_addr),
    .last  (scan_last)
  );
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = RUN;
          col_d     = '0;
          row_d     = '0;
          base_d    = BASE0;
          overrun_d = 1'b0;
        end
      end
      RUN: begin
        if (i_enb) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_W'(col_q);
          wr_data_d = i_data;
          if (col_q == COL_LAST) begin
            col_d  = '0;
            row_d  = row_q + RW'(1);
            base_d = base_q + ROW_STEP;
            if (row_q == ROW_LAST) begin
`ifdef FRAME_WRITER_BORDER_FILL_EN
              state_d = FILL;
`else
              state_d = DONE;
`endif
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      FILL: begin
`ifdef FRAME_WRITER_BORDER_FILL_EN
        wr_en_d   = 1'b1;
        wr_addr_d = scan_addr;
        wr_data_d = '0;
        if (scan_last) begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Pixels arriving outside RUN are dropped and flagged.
    if (i_enb && (state_q != RUN)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer on an 8x6 frame; border fill follows FRAME_WRITER_BORDER_FILL_EN.
module tb_frame_writer;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int IW   = W - 2;
  localparam int NPIX = (W - 2) * (H - 2);

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_enb = 1'b0;
  logic [7:0] i_data = '0;
  logic       o_wr_en;
  logic [5:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_busy;
  logic       o_done;
  logic       o_overrun;

  int  n_checks = 0;
  int  n_fail = 0;
  int  done_exp = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  frame_writer #(
    .IMG_W  (W),
    .IMG_H  (H),
    .PIX_W  (8),
    .ADDR_W (6)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_enb     (i_enb),
    .i_data    (i_data),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Interior pixel k lands at (k / IW + 1, k % IW + 1).
  function automatic wr_t pix_wr(input int k, input logic [7:0] d);
    wr_t e;
    e.a = 6'((k / IW + 1) * W + (k % IW) + 1);
    e.d = d;
    return e;
  endfunction

  function automatic wr_t zero_wr(input int a);
    wr_t e;
    e.a = 6'(a);
    e.d = 8'h00;
    return e;
  endfunction

  task automatic push_border();
    for (int c = 0; c < W; c++) exp_q.push_back(zero_wr(c));
    for (int r = 1; r < H - 1; r++) begin
      exp_q.push_back(zero_wr(r * W));
      exp_q.push_back(zero_wr(r * W + W - 1));
    end
    for (int c = 0; c < W; c++) exp_q.push_back(zero_wr((H - 1) * W + c));
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (o_wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                 o_wr_addr, o_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(o_wr_addr), 32'(mon_e.a));
        chk("wr_data", 32'(o_wr_data), 32'(mon_e.d));
        chk("busy_during_write", 32'(o_busy), 32'd1);
      end
    end
    if (o_done) begin
      chk("done_expected", 32'(done_exp > 0), 32'd1);
      chk("writes_before_done", 32'(exp_q.size()), 32'd0);
      chk("busy_low_with_done", 32'(o_busy), 32'd0);
      if (done_exp > 0) done_exp--;
    end
  end

  task automatic reset_chk();
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_enb   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(o_wr_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    exp_q.delete();
    done_exp = 0;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  // mode 0: back-to-back, data k+1; 1: enb toggles 1/0; 2: random gaps and data.
  task automatic run_frame(input int mode, input bit dup_start, input int npix);
    int k;
    int cyc;
    int budget;
    logic       en;
    logic [7:0] d;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    chk("overrun_cleared", 32'(o_overrun), 32'd0);
    k   = 0;
    cyc = 0;
    while (k < npix) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = (cyc % 2) == 0;
        default: en = $urandom_range(0, 2) != 0;
      endcase
      d = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'(k + 1);
      i_enb   = en;
      i_data  = d;
      i_start = dup_start && en && (k == 4);
      if (en) begin
        exp_q.push_back(pix_wr(k, d));
        k++;
      end
      cyc++;
      @(posedge clk);
      #1;
      chk("wr_en_mirrors_enb", 32'(o_wr_en), 32'(en));
      i_start = 1'b0;
    end
    i_enb = 1'b0;
    if (npix == NPIX) begin
`ifdef FRAME_WRITER_BORDER_FILL_EN
      push_border();
`endif
      done_exp++;
      budget = 0;
      while (done_exp > 0 && budget < 200) begin
        @(posedge clk);
        #1;
        budget++;
      end
      chk("done_within_budget", 32'(done_exp), 32'd0);
      chk("frame_writes_drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    reset_chk();

    // Pixel before any start is dropped and flagged.
    @(posedge clk);
    #1;
    i_enb  = 1'b1;
    i_data = 8'hAA;
    @(posedge clk);
    #1;
    i_enb = 1'b0;
    @(posedge clk);
    #1;
    chk("overrun_set", 32'(o_overrun), 32'd1);
    chk("no_busy_on_overrun", 32'(o_busy), 32'd0);

    run_frame(0, 1'b0, NPIX);
    run_frame(1, 1'b0, NPIX);

    run_frame(0, 1'b0, 10);
    reset_chk();
    run_frame(0, 1'b0, NPIX);

    run_frame(0, 1'b1, NPIX);

    for (int f = 0; f < 5; f++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_frame(2, 1'($urandom_range(0, 1)), NPIX);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(o_busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
